// File: rtl/rr_grant_scheduler_if.sv
// Request/grant bundle between eight requesters and the round-robin scheduler.
// The master side drives req; the slave side (the scheduler) drives the grant outputs.
interface rr_grant_scheduler_if;
   logic [7:0] req;
   logic [7:0] grant;
   logic [2:0] grant_id;
   logic       grant_valid;
   logic       preempt;

   modport master (output req, input grant, grant_id, grant_valid, preempt);
   modport slave  (input req, output grant, grant_id, grant_valid, preempt);
endinterface

// File: rtl/rr_grant_scheduler.sv
// Eight-way round-robin grant scheduler with registered one-hot grant and zero-bubble handover.
// Optional hold-time limiting (forced rotation with preempt pulse) is compiled in with ARB_TIMEOUT_EN.
module rr_grant_scheduler #(
   parameter int HOLD_MAX = 4
) (
   input  logic                clk,
   input  logic                rst,
   rr_grant_scheduler_if.slave bus
);

   typedef enum logic {IDLE, OWN} state_t;

   state_t     state_q, state_d;
   logic [2:0] ptr_q, ptr_d;
   logic [2:0] id_q, id_d;
   logic       preempt_q, preempt_d;
   logic [7:0] others;
   logic [3:0] pick_idle;
   logic [3:0] pick_rot;

   if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_bad_hold
      $error("rr_grant_scheduler: HOLD_MAX out of range 2..255");
   end

`ifdef ARB_TIMEOUT_EN
   localparam logic [7:0] HCNT_LIM = 8'(HOLD_MAX - 1);
   logic [7:0] hcnt_q, hcnt_d;
`endif

   // Returns {found, index} of the first set bit scanning start, start+1, ... modulo 8.
   function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] start);
      logic [3:0] res;
      logic [2:0] idx;
      res = 4'b0000;
      for (int i = 7; i >= 0; i--) begin
         idx = start + 3'(i);
         if (r[idx]) res = {1'b1, idx};
      end
      return res;
   endfunction

   // Masking the owner makes it lose to every other pending requester on rotation.
   assign others    = bus.req & ~(8'b0000_0001 << id_q);
   assign pick_idle = rr_pick(bus.req, ptr_q);
   assign pick_rot  = rr_pick(others, id_q + 3'd1);

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      id_d      = id_q;
      preempt_d = 1'b0;
`ifdef ARB_TIMEOUT_EN
      hcnt_d    = hcnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (pick_idle[3]) begin
               state_d = OWN;
               id_d    = pick_idle[2:0];
`ifdef ARB_TIMEOUT_EN
               hcnt_d  = 8'd0;
`endif
            end
         end
         OWN: begin
            if (!bus.req[id_q]) begin
               ptr_d = id_q + 3'd1;
`ifdef ARB_TIMEOUT_EN
               hcnt_d = 8'd0;
`endif
               if (pick_rot[3]) id_d = pick_rot[2:0];
               else state_d = IDLE;
            end
`ifdef ARB_TIMEOUT_EN
            else if (hcnt_q == HCNT_LIM && pick_rot[3]) begin
               ptr_d     = id_q + 3'd1;
               id_d      = pick_rot[2:0];
               hcnt_d    = 8'd0;
               preempt_d = 1'b1;
            end else if (hcnt_q != HCNT_LIM) begin
               hcnt_d = hcnt_q + 8'd1;
            end
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         ptr_q     <= 3'd0;
         id_q      <= 3'd0;
         preempt_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         id_q      <= id_d;
         preempt_q <= preempt_d;
      end
   end

`ifdef ARB_TIMEOUT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) hcnt_q <= 8'd0;
      else     hcnt_q <= hcnt_d;
   end
   assign bus.preempt = preempt_q;
`else
   assign bus.preempt = 1'b0;
`endif

   // All outputs decode from state/owner registers only; no path from req.
   assign bus.grant_valid = (state_q == OWN);
   assign bus.grant       = (state_q == OWN) ? (8'b0000_0001 << id_q) : 8'b0000_0000;
   assign bus.grant_id    = (state_q == OWN) ? id_q : 3'd0;

endmodule

// File: tb/tb_rr_grant_scheduler.sv
// Directed-vector bench for rr_grant_scheduler; timeout scenarios run when ARB_TIMEOUT_EN is defined.
module tb_rr_grant_scheduler;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;

   rr_grant_scheduler_if bus_if();

   rr_grant_scheduler #(.HOLD_MAX(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic check_idle(input string tag);
      check_eq({tag, "_grant"}, 32'(bus_if.grant), 32'h00);
      check_eq({tag, "_id"},    32'(bus_if.grant_id), 32'd0);
      check_eq({tag, "_valid"}, 32'(bus_if.grant_valid), 32'd0);
      check_eq({tag, "_preempt"}, 32'(bus_if.preempt), 32'd0);
   endtask

   task automatic check_owner(input string tag, input int id, input logic pre);
      check_eq({tag, "_id"},      32'(bus_if.grant_id), 32'(id));
      check_eq({tag, "_grant"},   32'(bus_if.grant), 32'(1) << id);
      check_eq({tag, "_valid"},   32'(bus_if.grant_valid), 32'd1);
      check_eq({tag, "_preempt"}, 32'(bus_if.preempt), 32'(pre));
   endtask

   initial begin
      bus_if.req = 8'h00;
      do_reset();
      check_idle("reset");

      // Single request: one-cycle latency, then drop.
      bus_if.req = 8'b0010_0000;
      tick();
      check_owner("single", 5, 1'b0);
      bus_if.req = 8'h00;
      tick();
      check_idle("single_rel");

      // Full rotation with wrap: ptr is 6 after owner 5 released; reset to scan from 0.
      do_reset();
      bus_if.req = 8'hFF;
      tick();
      check_owner("rot_first", 0, 1'b0);
      for (int o = 0; o < 8; o++) begin
         tick();
         check_owner("rot_hold", o, 1'b0);
         bus_if.req = 8'hFF & ~(8'b0000_0001 << o);
         tick();
         check_owner("rot_next", (o + 1) % 8, 1'b0);
         bus_if.req = 8'hFF;
      end
      bus_if.req = 8'h00;
      tick();
      check_idle("rot_end");

      // Pointer fairness: ptr=1 now; owner 6, then 0 and 2 before 6 again.
      bus_if.req = 8'b0100_0000;
      tick();
      check_owner("fair_own6", 6, 1'b0);
      bus_if.req = 8'b0000_0101;
      tick();
      check_owner("fair_wrap0", 0, 1'b0);
      bus_if.req = 8'b0100_0100;
      tick();
      check_owner("fair_next2", 2, 1'b0);
      bus_if.req = 8'b0100_0000;
      tick();
      check_owner("fair_last6", 6, 1'b0);
      bus_if.req = 8'h00;
      tick();
      check_idle("fair_end");

      // Asynchronous reset between edges while owner 3 holds.
      bus_if.req = 8'b0000_1000;
      tick();
      check_owner("ar_own3", 3, 1'b0);
      #2 rst = 1'b1;
      #1;
      check_idle("ar_async");
      bus_if.req = 8'b0000_1001;
      tick();
      rst = 1'b0;
      check_idle("ar_held");
      tick();
      check_owner("ar_post", 0, 1'b0);
      bus_if.req = 8'h00;
      tick();

`ifdef ARB_TIMEOUT_EN
      do_reset();
      bus_if.req = 8'b0000_0011;
      for (int c = 0; c < 4; c++) begin
         tick();
         check_owner("to_own0", 0, 1'b0);
      end
      tick();
      check_owner("to_pre1", 1, 1'b1);
      for (int c = 0; c < 3; c++) begin
         tick();
         check_owner("to_own1", 1, 1'b0);
      end
      tick();
      check_owner("to_pre0", 0, 1'b1);
      tick();
      check_owner("to_own0b", 0, 1'b0);

      do_reset();
      bus_if.req = 8'b1000_0000;
      for (int c = 0; c < 20; c++) begin
         tick();
         check_owner("to_sole7", 7, 1'b0);
      end
      bus_if.req = 8'b1000_0001;
      tick();
      check_owner("to_late0", 0, 1'b1);
`else
      do_reset();
      bus_if.req = 8'h03;
      for (int c = 0; c < 20; c++) begin
         tick();
         check_owner("nto_hold0", 0, 1'b0);
      end
`endif
      bus_if.req = 8'h00;
      tick();
      check_idle("final");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
